// File: rtl/microtile_sum_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microtile_pkg
// Description : Shared types and constants for the microtile sum UART
//               transmitter: FSM state encoding, data width and sum width.
//               The PARITY state exists only when MICROTILE_UART_PARITY_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package microtile_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int SUM_W          = 8;

    // Explicit encoding keeps the state register width fixed across builds
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef MICROTILE_UART_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } uart_state_t;

endpackage : microtile_pkg
`default_nettype wire

// File: rtl/microtile_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : microtile_sync_fifo
// Description : Single-clock FIFO with registered occupancy. A push into a
//               full FIFO is accepted only when a pop happens the same cycle.
//               Pointers wrap naturally because DEPTH is a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module microtile_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign full      = (r_level == C_FULL_LEVEL);
    assign empty     = (r_level == '0);
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign rd_data   = r_mem[r_rd_ptr];
    assign level     = r_level;

    // Storage array: data needs no reset, only the pointers do
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule : microtile_sync_fifo
`default_nettype wire

// File: rtl/microtile_sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : microtile_sum_uart_tx
// Description : Buffers 8-bit adder sums in a small FIFO and serialises each
//               one as a UART frame (8N1, or 8E1 when the build macro
//               MICROTILE_UART_PARITY_EN is defined) on a single pin.
// Revision    : 1.0 - initial release
// ============================================================================
module microtile_sum_uart_tx
    import microtile_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SUM_W-1:0]              sum_in,
    input  logic                          sum_valid,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    C_BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t      r_state;
    uart_state_t      w_state_next;
    logic [CW-1:0]    r_baud;
    logic [CW-1:0]    w_baud_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_next;
    logic [SUM_W-1:0] r_shift;
    logic [SUM_W-1:0] w_shift_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             r_overflow;
    logic             w_pop;
    logic             w_baud_done;
    logic [SUM_W-1:0] w_rd_data;
    logic             w_full;
    logic             w_empty;
`ifdef MICROTILE_UART_PARITY_EN
    logic             r_parity;
`endif

    microtile_sync_fifo #(
        .WIDTH (SUM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (sum_valid),
        .wr_data (sum_in),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .level   (fifo_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_baud_done = (r_baud == C_BAUD_LAST);
    assign busy        = (r_state != IDLE);
    assign tx          = r_tx;
    assign overflow    = r_overflow;

    // Next-state, baud/bit counters and the line level for the next cycle
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 1'b1;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_rd_data;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == C_BIT_LAST) begin
`ifdef MICROTILE_UART_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_next   = r_bit_idx + 1'b1;
                        w_shift_next = r_shift >> 1;
                    end
                end
            end
`ifdef MICROTILE_UART_PARITY_EN
            PARITY: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = IDLE;
            end
        endcase
        // tx is registered alongside the state so the line tracks it exactly
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef MICROTILE_UART_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

`ifdef MICROTILE_UART_PARITY_EN
    // Even parity is captured once per byte, at the moment it leaves the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_rd_data;
        end
    end
`endif

    // Sticky flag: a sum arrived while the FIFO was full and nothing drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (sum_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule : microtile_sum_uart_tx
`default_nettype wire

// File: tb/tb_microtile_sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_microtile_sum_uart_tx
// Description : Directed self-checking bench for microtile_sum_uart_tx with
//               CLKS_PER_BIT=4 and FIFO_DEPTH=4. A line monitor decodes
//               frames from tx; the main thread compares against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microtile_sum_uart_tx;

    localparam int CPB = 4;
`ifdef MICROTILE_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sum_in = 8'h00;
    logic       sum_valid = 1'b0;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_end = -100;
    int peak  = 0;

    logic [10:0] q_bits[$];
    bit          q_ok[$];
    int          q_gap[$];

    microtile_sum_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
    endtask

    task automatic push(input logic [7:0] v);
        sum_in    = v;
        sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (q_bits.size() < n && k < 2000) begin
            tick();
            k++;
        end
        check("frame_count", q_bits.size(), n);
    endtask

    task automatic clear_q();
        q_bits.delete();
        q_ok.delete();
        q_gap.delete();
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    // Line monitor: decodes one frame per falling edge, checking that each
    // bit is steady for CPB cycles, busy is high throughout and low after.
    initial begin : uart_monitor
        logic [10:0] bits;
        bit ok;
        bit ab;
        int start_cyc;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                bits = '0;
                ok = 1'b1;
                ab = 1'b0;
                start_cyc = cyc;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) ok = 1'b0;
                        if (busy !== 1'b1) ok = 1'b0;
                        if (rst_n !== 1'b1) ab = 1'b1;
                        if (!(b == NB - 1 && c == CPB - 1)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                if (bits[NB-1] !== 1'b1) ok = 1'b0;
                @(posedge clk);
                #1;
                if (busy !== 1'b0 || tx !== 1'b1) ok = 1'b0;
                if (rst_n !== 1'b1) ab = 1'b1;
                if (!ab) begin
                    q_bits.push_back(bits);
                    q_ok.push_back(ok);
                    q_gap.push_back(start_cyc - last_end - 1);
                end
                last_end = cyc - 1;
            end
        end
    end

    initial begin : main
        logic [10:0] fr;
        logic [7:0]  vals[6];
        logic [7:0]  exp_b[6];
        int          k;
        int          hi_bad;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        tick();
        clear_q();

        // ---------------- single frame 0x1E ----------------
        push(8'h1E);
        check("single_level_n1", fifo_level, 3'd1);
        check("single_tx_n1", tx, 1'b1);
        tick();
        check("single_tx_low_n2", tx, 1'b0);
        check("single_busy_n2", busy, 1'b1);
        wait_frames(1);
        if (q_bits.size() >= 1) begin
            fr = q_bits[0];
`ifdef MICROTILE_UART_PARITY_EN
            check("single_bits", fr, 11'h43C);
`else
            check("single_bits", fr, 11'h23C);
`endif
            check("single_ok", q_ok[0], 1'b1);
        end
        check("single_level_end", fifo_level, 3'd0);
        check("single_busy_end", busy, 1'b0);

        // ---------------- back-to-back frames ----------------
        clear_q();
        peak = 0;
        push(8'h00);
        push(8'hFF);
        push(8'h1F);
        check("b2b_level_after_push", fifo_level, 3'd2);
        wait_frames(3);
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h1F;
        for (int i = 0; i < 3; i++) begin
            if (q_bits.size() > i) begin
                fr = q_bits[i];
                check("b2b_data", fr[8:1], exp_b[i]);
                check("b2b_ok", q_ok[i], 1'b1);
                if (i > 0) check("b2b_gap", q_gap[i], 1);
            end
        end
        check("b2b_peak", peak, 2);
        check("b2b_ovf", overflow, 1'b0);

        // ---------------- overflow ----------------
        apply_reset();
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        vals[3] = 8'h44; vals[4] = 8'h55; vals[5] = 8'h66;
        for (int i = 0; i < 6; i++) begin
            push(vals[i]);
            if (i == 4) check("ovf_not_yet", overflow, 1'b0);
        end
        check("ovf_set", overflow, 1'b1);
        check("ovf_level_full", fifo_level, 3'd4);
        wait_frames(5);
        for (int i = 0; i < 5; i++) begin
            if (q_bits.size() > i) begin
                fr = q_bits[i];
                check("ovf_data", fr[8:1], vals[i]);
                check("ovf_ok", q_ok[i], 1'b1);
            end
        end
        repeat (3 * NB * CPB) tick();
        check("ovf_no_sixth", q_bits.size(), 5);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_level_drained", fifo_level, 3'd0);

        // ---------------- full + pop same cycle ----------------
        apply_reset();
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
        vals[3] = 8'h04; vals[4] = 8'h05; vals[5] = 8'h6F;
        for (int i = 0; i < 5; i++) push(vals[i]);
        check("fp_full", fifo_level, 3'd4);
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check("fp_idle_reached", busy, 1'b0);
        check("fp_full_at_idle", fifo_level, 3'd4);
        push(vals[5]);
        check("fp_level_kept", fifo_level, 3'd4);
        check("fp_ovf_clear", overflow, 1'b0);
        wait_frames(6);
        for (int i = 0; i < 6; i++) begin
            if (q_bits.size() > i) begin
                fr = q_bits[i];
                check("fp_data", fr[8:1], vals[i]);
            end
        end
        check("fp_ovf_end", overflow, 1'b0);

        // ---------------- reset mid-frame ----------------
        apply_reset();
        push(8'hA5);
        push(8'h5A);
        k = 0;
        while (tx !== 1'b0 && k < 50) begin
            tick();
            k++;
        end
        check("mid_start_seen", tx, 1'b0);
        repeat (CPB + 3 * CPB + 1) tick();
        check("mid_busy_before", busy, 1'b1);
        check("mid_level_before", fifo_level, 3'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_async_tx", tx, 1'b1);
        check("mid_async_busy", busy, 1'b0);
        check("mid_async_level", fifo_level, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_q();
        hi_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) hi_bad++;
        end
        check("mid_no_residual", hi_bad, 0);
        check("mid_no_frames", q_bits.size(), 0);

`ifdef MICROTILE_UART_PARITY_EN
        // ---------------- parity frame 0x07 ----------------
        clear_q();
        push(8'h07);
        wait_frames(1);
        if (q_bits.size() >= 1) begin
            fr = q_bits[0];
            check("par_bits", fr, 11'h60E);
            check("par_bit", fr[9], 1'b1);
            check("par_ok", q_ok[0], 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_microtile_sum_uart_tx
`default_nettype wire
